// File: rtl/regfile.sv
// ----------------------------------------------------------------------------
// regfile: 32 x 32-bit RV32I integer register file.
//
// Two combinational read ports serve the decode stage; one synchronous write
// port is driven by write-back. A write presented in the same cycle as a read
// of the same register is forwarded to the read port. x0 always reads zero.
//
// Ports:
//   i_clk     system clock, all state updates on the rising edge
//   i_rst     synchronous reset, active low
//   i_we      write enable
//   i_waddr   write register index
//   i_wdata   write data
//   i_re1     read port 1 enable
//   i_raddr1  read port 1 index
//   o_rdata1  read port 1 data
//   i_re2     read port 2 enable
//   i_raddr2  read port 2 index
//   o_rdata2  read port 2 data
// ----------------------------------------------------------------------------
module regfile (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic        i_re1,
    input  logic [4:0]  i_raddr1,
    output logic [31:0] o_rdata1,
    input  logic        i_re2,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata2
);

    logic [31:0] r_regs [32];

    // Entry 0 is cleared by reset and never written afterwards.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read port 1: reset, disable and x0 force zero before forwarding is considered.
    always_comb begin
        o_rdata1 = '0;
        if (!i_rst || !i_re1 || (i_raddr1 == 5'd0)) begin
            o_rdata1 = '0;
        end else if (i_we && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end else begin
            o_rdata1 = r_regs[i_raddr1];
        end
    end

    // Read port 2: identical priority to port 1.
    always_comb begin
        o_rdata2 = '0;
        if (!i_rst || !i_re2 || (i_raddr2 == 5'd0)) begin
            o_rdata2 = '0;
        end else if (i_we && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end else begin
            o_rdata2 = r_regs[i_raddr2];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// ----------------------------------------------------------------------------
// tb_regfile: directed and randomized checks of regfile against a simple
// array-based reference model.
// ----------------------------------------------------------------------------
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model of the architectural register contents.
    logic [31:0] model [32];

    regfile u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_we     (we),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .i_re1    (re1),
        .i_raddr1 (raddr1),
        .o_rdata1 (rdata1),
        .i_re2    (re2),
        .i_raddr2 (raddr2),
        .o_rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected read data from the current inputs and the model contents.
    function automatic logic [31:0] model_read(input logic ren, input logic [4:0] ra);
        if (!rst) return 32'h0;
        if (!ren) return 32'h0;
        if (ra == 5'd0) return 32'h0;
        if (we && (waddr == ra)) return wdata;
        return model[ra];
    endfunction

    // Drive one cycle of inputs, check both ports mid-cycle, then advance the
    // model across the rising edge.
    task automatic do_cycle(input string tag,
                            input logic r, input logic w, input logic [4:0] wa,
                            input logic [31:0] wd,
                            input logic e1, input logic [4:0] a1,
                            input logic e2, input logic [4:0] a2);
        rst    = r;
        we     = w;
        waddr  = wa;
        wdata  = wd;
        re1    = e1;
        raddr1 = a1;
        re2    = e2;
        raddr2 = a2;
        @(negedge clk);
        check_eq({tag, "_p1"}, rdata1, model_read(re1, raddr1));
        check_eq({tag, "_p2"}, rdata2, model_read(re2, raddr2));
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && (waddr != 5'd0)) begin
            model[waddr] = wdata;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        @(posedge clk);
        #1;

        // Reset: outputs held at zero even with reads enabled.
        do_cycle("reset_hold", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd9);
        check_eq("reset_direct", rdata1 | rdata2, 32'h0);

        // Reset clear of a written register.
        do_cycle("rc_write", 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        do_cycle("rc_rst",   1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
        do_cycle("rc_read",  1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
        check_eq("rc_x5_zero", rdata1, 32'h0);

        // Write then read; port 2 disabled on the same index.
        do_cycle("wr_x10",  1'b1, 1'b1, 5'd10, 32'h0000_0123, 1'b0, 5'd0, 1'b0, 5'd0);
        do_cycle("rd_x10",  1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0, 5'd10);
        check_eq("rd_x10_abs", rdata1, 32'h0000_0123);

        // Forwarding on both ports, then readback from storage.
        do_cycle("fwd_x7",  1'b1, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 1'b1, 5'd7);
        do_cycle("post_x7", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
        check_eq("post_x7_abs", rdata2, 32'hA5A5_A5A5);

        // x0 hardwire, including no forwarding.
        do_cycle("x0_wr", 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        do_cycle("x0_rd", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);

        // Sweep every register with a distinct pattern.
        for (int i = 1; i < 32; i++) begin
            do_cycle("sweep_wr", 1'b1, 1'b1, 5'(i), 32'(i) * 32'h0101_0101,
                     1'b0, 5'd0, 1'b0, 5'd0);
        end
        for (int i = 1; i < 32; i++) begin
            do_cycle("sweep_rd", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(32 - i));
            check_eq("sweep_abs_p1", rdata1, 32'(i) * 32'h0101_0101);
            check_eq("sweep_abs_p2", rdata2, 32'(32 - i) * 32'h0101_0101);
        end

        // Reset with a concurrent write discards the write.
        do_cycle("rw_rst", 1'b0, 1'b1, 5'd3, 32'h0000_1234, 1'b1, 5'd3, 1'b1, 5'd3);
        do_cycle("rw_rd",  1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd4);
        check_eq("rw_x3_zero", rdata1, 32'h0);

        // Randomized traffic with occasional resets and forced address aliasing.
        for (int n = 0; n < 400; n++) begin
            logic        r_r, r_w, r_e1, r_e2;
            logic [4:0]  r_wa, r_a1, r_a2;
            logic [31:0] r_wd;
            r_r  = ($urandom_range(0, 29) != 0);
            r_w  = ($urandom_range(0, 3) != 0);
            r_wa = 5'($urandom_range(0, 31));
            r_wd = $urandom;
            r_e1 = ($urandom_range(0, 5) != 0);
            r_e2 = ($urandom_range(0, 5) != 0);
            r_a1 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            r_a2 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            do_cycle("rand", r_r, r_w, r_wa, r_wd, r_e1, r_a1, r_e2, r_a2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

32 × 32-bit RV32I integer register file; responder to the decode stage's two read requests and the target of the write-back stage's single write port. Reads are combinational so decode gets operands in the same cycle. Writes are synchronous. Same-cycle write-to-read forwarding is built in, so an instruction being decoded sees a result written back that cycle. Register x0 is hardwired to zero.

## Interface
- No parameters. Widths are fixed by `RegBus` (32) and `RegAddrBus` (5).
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low; sampled on clk rising edge
- we  in  1  write enable from write-back (`WriteEnable` = 1)
- waddr  in  5  write register index
- wdata  in  32  write data
- re1  in  1  read-port-1 enable (decode reg1_read)
- raddr1  in  5  read-port-1 index (decode reg1_addr, inst[19:15])
- rdata1  out  32  read-port-1 data (to decode reg1_data)
- re2  in  1  read-port-2 enable (decode reg2_read)
- raddr2  in  5  read-port-2 index (decode reg2_addr, inst[24:20])
- rdata2  out  32  read-port-2 data (to decode reg2_data)

## Operation
- Storage: regs[0..31], 32 bits each. regs[0] is never written and always reads as 0.
- Reset: on a rising clk with rst = 0, all 32 entries clear to 0x0000_0000 in that single edge. A write presented in the same cycle is discarded.
- Write: on a rising clk with rst = 1, we = 1 and waddr ≠ 0, regs[waddr] ← wdata. A write with waddr = 0 is ignored silently.
- Read priority, evaluated independently per port n, highest first:
  1. rst = 0 → rdatan = 0
  2. ren = 0 → rdatan = 0
  3. raddrn = 0 → rdatan = 0
  4. we = 1 and waddr = raddrn → rdatan = wdata (forwarding)
  5. otherwise rdatan = regs[raddrn]
- Both ports may address the same register; both return identical data, including the forwarded value.
- No X propagation: every output is a defined function of inputs and state in all cycles.

## Timing
- Read latency: 0 cycles, purely combinational from re/raddr/we/waddr/wdata/rst to rdata.
- Write latency: 1 edge. Data is in the array after the rising edge. The same-cycle read sees it through forwarding; later cycles see it from storage.
- Back-to-back writes to the same index: the last edge wins.
- Reset mid-operation: asserting rst forces rdata1/rdata2 to 0 at once (combinationally) and clears the array at the next edge. Once rst deasserts, every register reads 0 until it is written.
- Outputs while rst = 0: rdata1 = rdata2 = 0.
- No handshake and no back-pressure: every write request is accepted on the edge it is presented.

## Test plan
- Reset clear: write 0xDEADBEEF to x5, hold rst = 0 for one edge, release, then read x5 on port 1 → 0x0000_0000.
- Write then read: write 0x0000_0123 to x10. Next cycle, re1 = 1 with raddr1 = 10 → 0x0000_0123. Same cycle, re2 = 0 with raddr2 = 10 → 0.
- Forwarding: in one cycle, we = 1, waddr = 7, wdata = 0xA5A5_A5A5, re1 = re2 = 1, raddr1 = raddr2 = 7 → both ports 0xA5A5_A5A5 combinationally, before the edge. After the edge, the stored value is the same.
- x0 hardwire: write 0xFFFF_FFFF to x0 with we = 1, then read x0 on both ports → 0, including in the same cycle (no forwarding for x0).
- Sweep: write value (i × 0x0101_0101) to each of x1..x31, then read each on port 1 and x(32−i) on port 2 concurrently → the expected values on both ports, with no aliasing.
- Reset with concurrent write: rst = 0 and we = 1 to x3 with 0x1234 in the same cycle → after the edge, x3 reads 0.
